// File: rtl/instr_fetch_unit.sv
// KGP-RISC fetch stage: PC register, variable-latency imem handshake and branch resolution.
// Optional macro FETCH_TIMEOUT_EN bounds the imem wait and raises a sticky fetch_err.
module instr_fetch_unit #(
    parameter int unsigned           ADDR_W         = 32,
    parameter logic [ADDR_W-1:0]     RESET_PC       = '0,
    parameter int unsigned           TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_valid,
    output logic [31:0]       instruction,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] next_pc,
    input  logic [2:0]        branch,
    input  logic [31:0]       pda,
    input  logic [31:0]       rs_value,
    input  logic              zero,
    input  logic              sign,
    input  logic              carry,
    input  logic              halt,
    output logic              fetch_err,
    output logic [ADDR_W-1:0] pc
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_EXEC = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] rel_target;
    logic [ADDR_W-1:0] target;
    logic              taken;
    logic              timeout_hit;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt_q;
    logic             err_q;

    // Counts completed WAIT cycles; zero on the first WAIT cycle after REQ.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= '0;
        end else if (state_q == S_WAIT) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
        end else begin
            wait_cnt_q <= '0;
        end
    end

    assign timeout_hit = (state_q == S_WAIT) && !imem_valid &&
                         (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (timeout_hit) begin
            err_q <= 1'b1;
        end
    end

    assign fetch_err = err_q;
`else
    // Parameter is only meaningful with the timeout enabled; referenced to keep it live.
    assign timeout_hit = (TIMEOUT_CYCLES == 0) && 1'b0;
    assign fetch_err   = 1'b0;
`endif

    assign pc_plus4   = pc_q + ADDR_W'(4);
    assign rel_target = pc_plus4 + ADDR_W'(pda);

    always_comb begin
        taken = 1'b0;
        case (branch)
            3'b011:  taken = sign;
            3'b100:  taken = zero;
            3'b101:  taken = !zero;
            3'b110:  taken = carry;
            3'b111:  taken = !carry;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        target = pc_plus4;
        case (branch)
            3'b000:  target = pc_plus4;
            3'b001:  target = rel_target;
            3'b010:  target = ADDR_W'(rs_value);
            default: target = taken ? rel_target : pc_plus4;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            S_REQ: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (imem_valid) begin
                    instr_d = imem_rdata;
                    state_d = S_EXEC;
                end else if (timeout_hit) begin
                    state_d = S_HALT;
                end
            end
            S_EXEC: begin
                pc_d    = {target[ADDR_W-1:2], 2'b00};
                state_d = halt ? S_HALT : S_REQ;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    // Reset leaves state at REQ; gating keeps the request low until rst is released.
    assign imem_req    = ((state_q == S_REQ) || (state_q == S_WAIT)) && !rst;
    assign imem_addr   = {pc_q[ADDR_W-1:2], 2'b00};
    assign instr_valid = (state_q == S_EXEC);
    assign instruction = instr_q;
    assign next_pc     = pc_plus4;
    assign pc          = pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed, table-driven bench for instr_fetch_unit with a zero-wait / manual imem model.
// Covers the FETCH_TIMEOUT_EN build when the macro is defined.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [31:0] next_pc;
    logic [2:0]  branch;
    logic [31:0] pda;
    logic [31:0] rs_value;
    logic        zero;
    logic        sign;
    logic        carry;
    logic        halt;
    logic        fetch_err;
    logic [31:0] pc;

    logic        mem_auto;
    logic        man_valid;

    int checks;
    int errors;

    instr_fetch_unit #(
        .ADDR_W(32),
        .RESET_PC(32'h0000_0000),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_rdata(imem_rdata),
        .imem_valid(imem_valid),
        .instruction(instruction),
        .instr_valid(instr_valid),
        .next_pc(next_pc),
        .branch(branch),
        .pda(pda),
        .rs_value(rs_value),
        .zero(zero),
        .sign(sign),
        .carry(carry),
        .halt(halt),
        .fetch_err(fetch_err),
        .pc(pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        imem_rdata = 32'h1111_0000 + imem_addr;
        imem_valid = mem_auto ? imem_req : man_valid;
    end

    typedef struct {
        logic [2:0]  br;
        logic [31:0] pda;
        logic [31:0] rs;
        logic        z;
        logic        s;
        logic        c;
        logic [31:0] exp_pc;
        logic [31:0] exp_tgt;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs[NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic wait_exec(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (instr_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk(name, {31'b0, seen}, 32'd1);
    endtask

    task automatic idle_inputs();
        branch   = 3'b000;
        pda      = '0;
        rs_value = '0;
        zero     = 1'b0;
        sign     = 1'b0;
        carry    = 1'b0;
        halt     = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        //          br      pda            rs             z     s     c     exp_pc         exp_tgt
        vecs[0]  = '{3'b000, 32'h0,         32'h0,         1'b0, 1'b0, 1'b0, 32'h0000_000C, 32'h0000_0010};
        vecs[1]  = '{3'b001, 32'hFFFF_FFF0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'h0000_0004};
        vecs[2]  = '{3'b001, 32'h0000_0038, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0000_0004, 32'h0000_0040};
        vecs[3]  = '{3'b100, 32'h0000_0020, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0000_0064};
        vecs[4]  = '{3'b001, 32'hFFFF_FFD8, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0000_0064, 32'h0000_0040};
        vecs[5]  = '{3'b100, 32'h0000_0020, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0000_0040, 32'h0000_0044};
        vecs[6]  = '{3'b010, 32'h0,         32'h0000_0103, 1'b0, 1'b0, 1'b0, 32'h0000_0044, 32'h0000_0100};
        vecs[7]  = '{3'b011, 32'h0000_0010, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_0114};
        vecs[8]  = '{3'b011, 32'h0000_0010, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0000_0114, 32'h0000_0118};
        vecs[9]  = '{3'b101, 32'h0000_0008, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0000_0118, 32'h0000_0124};
        vecs[10] = '{3'b101, 32'h0000_0008, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0000_0124, 32'h0000_0128};
        vecs[11] = '{3'b110, 32'hFFFF_FFF8, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0000_0128, 32'h0000_0124};
        vecs[12] = '{3'b110, 32'hFFFF_FFF8, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0000_0124, 32'h0000_0128};
        vecs[13] = '{3'b111, 32'h0000_0004, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0000_0128, 32'h0000_0130};
        vecs[14] = '{3'b111, 32'h0000_0004, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0000_0130, 32'h0000_0134};
        vecs[15] = '{3'b001, 32'h0000_0006, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0000_0134, 32'h0000_013C};
        vecs[16] = '{3'b010, 32'h0,         32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 32'h0000_013C, 32'hFFFF_FFFC};
        vecs[17] = '{3'b000, 32'h0,         32'h0,         1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000};

        idle_inputs();
        mem_auto  = 1'b1;
        man_valid = 1'b0;
        rst       = 1'b1;

        #3;
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
        chk("rst_fetch_err", {31'b0, fetch_err}, 32'd0);
        chk("rst_instruction", instruction, 32'h0);

        // Zero-wait memory: REQ, WAIT, EXEC repeating, addresses 0,4,8,12.
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            chk($sformatf("seq_valid_%0d", k), {31'b0, instr_valid}, {31'b0, (k % 3) == 2});
            chk($sformatf("seq_req_%0d", k), {31'b0, imem_req}, {31'b0, (k % 3) != 2});
            chk($sformatf("seq_addr_%0d", k), imem_addr, 32'(4 * (k / 3)));
        end

        for (int i = 0; i < NVEC; i++) begin
            wait_exec($sformatf("vec%0d_exec", i));
            chk($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
            chk($sformatf("vec%0d_next_pc", i), next_pc, vecs[i].exp_pc + 32'd4);
            chk($sformatf("vec%0d_instr", i), instruction, 32'h1111_0000 + vecs[i].exp_pc);
            branch   = vecs[i].br;
            pda      = vecs[i].pda;
            rs_value = vecs[i].rs;
            zero     = vecs[i].z;
            sign     = vecs[i].s;
            carry    = vecs[i].c;
            @(negedge clk);
            idle_inputs();
            chk($sformatf("vec%0d_target", i), imem_addr, vecs[i].exp_tgt);
            chk($sformatf("vec%0d_req", i), {31'b0, imem_req}, 32'd1);
            chk($sformatf("vec%0d_valid_low", i), {31'b0, instr_valid}, 32'd0);
        end

        // Halt: pc still advances, then everything stays quiet until reset.
        wait_exec("halt_exec");
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("halt_req_%0d", i), {31'b0, imem_req}, 32'd0);
            chk($sformatf("halt_valid_%0d", i), {31'b0, instr_valid}, 32'd0);
            @(negedge clk);
        end
        chk("halt_pc", pc, 32'h4);
        chk("halt_instr_hold", instruction, 32'h1111_0000);

        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_pc", pc, 32'h0);
        chk("async_rst_req", {31'b0, imem_req}, 32'd0);
        chk("async_rst_instr", instruction, 32'h0);
        @(negedge clk);
        mem_auto  = 1'b0;
        man_valid = 1'b0;
        rst       = 1'b0;

`ifdef FETCH_TIMEOUT_EN
        for (int w = 1; w <= 4; w++) begin
            @(negedge clk);
            chk($sformatf("to_wait%0d_err", w), {31'b0, fetch_err}, 32'd0);
            chk($sformatf("to_wait%0d_req", w), {31'b0, imem_req}, 32'd1);
        end
        @(negedge clk);
        chk("to_err_set", {31'b0, fetch_err}, 32'd1);
        chk("to_req_drop", {31'b0, imem_req}, 32'd0);
        repeat (3) @(negedge clk);
        chk("to_err_sticky", {31'b0, fetch_err}, 32'd1);
        chk("to_halt_valid", {31'b0, instr_valid}, 32'd0);
        rst = 1'b1;
        #1;
        chk("to_err_rst", {31'b0, fetch_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        man_valid = 1'b1;
        @(negedge clk);
        man_valid = 1'b0;
        chk("to_late_valid_exec", {31'b0, instr_valid}, 32'd1);
        chk("to_late_valid_err", {31'b0, fetch_err}, 32'd0);
        chk("to_late_valid_instr", instruction, 32'h1111_0000);
`else
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            chk($sformatf("wait_req_%0d", i), {31'b0, imem_req}, 32'd1);
            chk($sformatf("wait_valid_%0d", i), {31'b0, instr_valid}, 32'd0);
        end
        chk("wait_err_tied", {31'b0, fetch_err}, 32'd0);
        man_valid = 1'b1;
        @(negedge clk);
        man_valid = 1'b0;
        chk("slow_mem_exec", {31'b0, instr_valid}, 32'd1);
        chk("slow_mem_instr", instruction, 32'h1111_0000);
        chk("slow_mem_err", {31'b0, fetch_err}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front-end stage of the KGP-RISC core; sits directly upstream of data_path.
- Holds the program counter and issues word fetches to a variable-latency instruction memory.
- Presents each fetched instruction to data_path for one execute cycle, then resolves branches from the control branch code and the ALU flags to form the next PC.
- Also supplies PC+4 for the link write-back path (mem_to_reg = 2).

Parameters:
- ADDR_W, 32, PC / instruction-memory byte-address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT_CYCLES, 16, imem wait limit (used only with FETCH_TIMEOUT_EN).

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request, held until accepted.
- imem_addr  out  ADDR_W  fetch byte address, always word-aligned.
- imem_rdata  in  32  fetched instruction word.
- imem_valid  in  1  rdata valid; completes the outstanding request.
- instruction  out  32  instruction to data_path decoder; stable during the EXEC cycle.
- instr_valid  out  1  one-cycle pulse: data_path executes and register file writes this cycle.
- next_pc  out  ADDR_W  PC+4 of the executing instruction (link value).
- branch  in  3  branch code from control, sampled in EXEC.
- pda  in  32  sign-extended byte offset from bit_extend_unit.
- rs_value  in  32  register value used by br.
- zero, sign, carry  in  1 each  ALU flags of the executing instruction.
- halt  in  1  control halt request, sampled in EXEC.
- fetch_err  out  1  sticky fetch-timeout flag.
- pc  out  ADDR_W  current PC (debug).

Behaviour:
- Reset (async, rst=1):
  - pc=RESET_PC, state=REQ, instruction=0, instr_valid=0, imem_req=0, fetch_err=0.
  - imem_req asserts on the first clock after rst deasserts.
- States: REQ, WAIT, EXEC, HALT.
- REQ:
  - imem_req=1, imem_addr=pc, go to WAIT.
- WAIT:
  - imem_req stays 1, imem_addr=pc.
  - On imem_valid=1: latch imem_rdata into instruction, drop imem_req, go to EXEC.
  - Minimum fetch-to-issue latency: 2 cycles after REQ (zero-wait memory gives REQ, WAIT, EXEC).
- EXEC:
  - instr_valid=1 for exactly this cycle; next_pc=pc+4.
  - Branch resolution is combinational on branch and the flags; pc updates at the end of EXEC.
  - Branch codes:
    - 000 none: pc+4.
    - 001 b: pc+4+pda.
    - 010 br: rs_value.
    - 011 bltz: sign.
    - 100 bz: zero.
    - 101 bnz: !zero.
    - 110 bcy: carry.
    - 111 bncy: !carry.
  - Conditional codes 011–111 take pc+4+pda when the condition is true, else pc+4.
  - Bits [1:0] of every computed target are forced to 0.
  - All additions are modulo 2^ADDR_W; wrap-around from 32'hFFFF_FFFC to 0 is legal and not flagged.
  - If halt=1: pc still updates, next state is HALT; otherwise next state is REQ.
- HALT:
  - imem_req=0, instr_valid=0; pc and instruction hold.
  - Exit only via rst.
- imem_valid outside WAIT is ignored; no request is ever dropped once issued.
- instruction holds its last value outside EXEC.
- Reset mid-WAIT abandons the request; a late imem_valid after reset is ignored because state is REQ, not WAIT.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT and clears on entry to WAIT.
  - When the count reaches TIMEOUT_CYCLES with no imem_valid: set fetch_err=1 (sticky until rst), drop imem_req, go to HALT.
  - imem_valid arriving in the same cycle the count reaches the limit wins, and the fetch completes normally.
- Undefined:
  - No counter; WAIT is unbounded; fetch_err is tied 0.

Test Plan:
- Reset, zero-wait memory returning 32'h1111_0000+addr → instr_valid pulses every 3rd cycle; imem_addr sequence 0, 4, 8, 12.
- EXEC at pc=0x10, branch=001, pda=32'hFFFF_FFF0 → next imem_addr=0x04; next_pc during EXEC=0x14.
- branch=100: zero=1, pda=0x20 at pc=0x40 → target 0x64; zero=0 → target 0x44.
- branch=010, rs_value=32'h0000_0103 → imem_addr=0x100 (low bits cleared); pc=32'hFFFF_FFFC with branch=000 → wraps to 0.
- halt=1 in EXEC → imem_req stays 0 for 20 cycles and instr_valid stays 0; then rst pulse mid-cycle → pc=RESET_PC immediately.
- FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=4, imem_valid held 0 → fetch_err=1 after 4 WAIT cycles, state HALT; repeat with imem_valid on the 4th cycle → normal EXEC, fetch_err=0.
